// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot scan decoder.
package decoder_pkg;

    // Widest select supported by the helpers below; callers cast to their own width.
    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // One-hot decode of an index, computed at full width.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx_in);
        onehot = 64'd1 << idx_in;
    endfunction

    // Output polarity: active-low designs invert every line.
    function automatic logic [MAX_OUT_W-1:0] apply_pol(input logic [MAX_OUT_W-1:0] v,
                                                      input logic act_low);
        if (act_low) begin
            apply_pol = ~v;
        end else begin
            apply_pol = v;
        end
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that times how long each scan line is held.
// load sets DWELL-1, clr sets 0, dec counts down; expire flags a zero count.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clr,
    input  logic i_dec,
    output logic o_expire
);

    localparam int CNT_W = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};

    logic [CNT_W-1:0] r_cnt;

    // Count register: load has priority over clear, clear over decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= ZERO;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_clr) begin
            r_cnt <= ZERO;
        end else if (i_dec && (r_cnt != ZERO)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = (r_cnt == ZERO);

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a built-in scan sequencer.
// DIRECT registers a decode of sel; SCAN walks the active line from the
// entry index, holding each line for DWELL cycles.
module onehot_scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL   = 4,
    parameter int ACT_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [(2**SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        idx,
    output logic                    step,
    output logic                    active
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic ACT_LOW_B = (ACT_LOW != 0);
    localparam logic [OUT_W-1:0] Y_IDLE = OUT_W'(apply_pol({MAX_OUT_W{1'b0}}, ACT_LOW_B));

    state_t             r_state;
    state_t             w_nxt_state;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_nxt_idx;
    logic               r_step;
    logic               w_nxt_step;
    logic               r_active;
    logic [OUT_W-1:0]   r_y;
    logic [OUT_W-1:0]   w_nxt_y;
    logic               w_load;
    logic               w_clr;
    logic               w_dec;
    logic               w_expire;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_clr    (w_clr),
        .i_dec    (w_dec),
        .o_expire (w_expire)
    );

    // Next state, next index and timer control; en=0 beats mode change beats expiry.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_step  = 1'b0;
        w_load      = 1'b0;
        w_clr       = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!en) begin
                    w_nxt_state = IDLE;
                end else if (mode) begin
                    w_nxt_state = SCAN;
                    w_nxt_idx   = sel;
                    w_load      = 1'b1;
                end else begin
                    w_nxt_state = DIRECT;
                    w_nxt_idx   = sel;
                    w_clr       = 1'b1;
                end
            end
            DIRECT: begin
                if (!en) begin
                    w_nxt_state = IDLE;
                    w_clr       = 1'b1;
                end else if (mode) begin
                    w_nxt_state = SCAN;
                    w_nxt_idx   = sel;
                    w_load      = 1'b1;
                end else begin
                    w_nxt_state = DIRECT;
                    w_nxt_idx   = sel;
                    w_clr       = 1'b1;
                end
            end
            SCAN: begin
                if (!en) begin
                    w_nxt_state = IDLE;
                    w_clr       = 1'b1;
                end else if (!mode) begin
                    w_nxt_state = DIRECT;
                    w_nxt_idx   = sel;
                    w_clr       = 1'b1;
                end else if (w_expire) begin
                    // Index wraps naturally at SEL_W bits.
                    w_nxt_state = SCAN;
                    w_nxt_idx   = r_idx + SEL_W'(1'b1);
                    w_nxt_step  = 1'b1;
                    w_load      = 1'b1;
                end else begin
                    w_nxt_state = SCAN;
                    w_dec       = 1'b1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_clr       = 1'b1;
            end
        endcase
    end

    // Output decode of the index that will be registered this edge.
    always_comb begin
        w_nxt_y = Y_IDLE;
        if (w_nxt_state == IDLE) begin
            w_nxt_y = Y_IDLE;
        end else begin
            w_nxt_y = OUT_W'(apply_pol(onehot(MAX_SEL_W'(w_nxt_idx)), ACT_LOW_B));
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= {SEL_W{1'b0}};
            r_step   <= 1'b0;
            r_active <= 1'b0;
            r_y      <= Y_IDLE;
        end else begin
            r_state  <= w_nxt_state;
            r_idx    <= w_nxt_idx;
            r_step   <= w_nxt_step;
            r_active <= (w_nxt_state != IDLE);
            r_y      <= w_nxt_y;
        end
    end

    assign y      = r_y;
    assign idx    = r_idx;
    assign step   = r_step;
    assign active = r_active;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Self-checking bench: three decoder instances (DWELL=4, DWELL=1, ACT_LOW=1)
// share one stimulus; expectations go through a scoreboard queue.
module tb_onehot_scan_decoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] sel;

    logic [7:0] y_w   [3];
    logic [2:0] idx_w [3];
    logic       step_w[3];
    logic       act_w [3];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         dut;
        string      nm;
        logic [7:0] y;
        logic [2:0] idx;
        logic       step;
        logic       act;
    } exp_t;

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] sel;
        logic [7:0] y;
        logic [2:0] idx;
        logic       step;
        logic       act;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[19];

    onehot_scan_decoder #(.SEL_W(3), .DWELL(4), .ACT_LOW(0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .y(y_w[0]), .idx(idx_w[0]), .step(step_w[0]), .active(act_w[0]));

    onehot_scan_decoder #(.SEL_W(3), .DWELL(1), .ACT_LOW(0)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .y(y_w[1]), .idx(idx_w[1]), .step(step_w[1]), .active(act_w[1]));

    onehot_scan_decoder #(.SEL_W(3), .DWELL(4), .ACT_LOW(1)) u_al (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .y(y_w[2]), .idx(idx_w[2]), .step(step_w[2]), .active(act_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input int d, input string nm, input logic [7:0] ey,
                           input logic [2:0] ei, input logic es, input logic ea);
        chk({nm, " y"},      y_w[d],              ey);
        chk({nm, " idx"},    {5'd0, idx_w[d]},    {5'd0, ei});
        chk({nm, " step"},   {7'd0, step_w[d]},   {7'd0, es});
        chk({nm, " active"}, {7'd0, act_w[d]},    {7'd0, ea});
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic cycle(input logic e, input logic m, input logic [2:0] s, input int d,
                         input logic [7:0] ey, input logic [2:0] ei, input logic es,
                         input logic ea, input string nm);
        exp_t x;
        exp_t p;
        en   = e;
        mode = m;
        sel  = s;
        x.dut = d; x.nm = nm; x.y = ey; x.idx = ei; x.step = es; x.act = ea;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard: got empty queue expected entry", nm);
        end else begin
            p = sb_q.pop_front();
            chk_all(p.dut, p.nm, p.y, p.idx, p.step, p.act);
        end
    endtask

    // Synchronous-looking reset pulse; leaves the bench 1 ns after a rising edge.
    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        sel  = 3'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        //            en    mode  sel   y      idx   step  act
        vecs[0]  = '{1'b1, 1'b0, 3'd5, 8'h20, 3'd5, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 3'd7, 8'h80, 3'd7, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 3'd3, 8'h08, 3'd3, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 3'd6, 8'h00, 3'd3, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'd1, 8'h00, 3'd3, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'd1, 8'h02, 3'd1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 3'd6, 8'h40, 3'd6, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 3'd2, 8'h40, 3'd6, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 3'd2, 8'h40, 3'd6, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 3'd2, 8'h40, 3'd6, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 3'd2, 8'h80, 3'd7, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 3'd2, 8'h80, 3'd7, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 3'd2, 8'h80, 3'd7, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 3'd2, 8'h80, 3'd7, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 3'd2, 8'h01, 3'd0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 3'd2, 8'h01, 3'd0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 3'd4, 8'h10, 3'd4, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 3'd4, 8'h00, 3'd4, 1'b0, 1'b0};

        // Reset state of every instance.
        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        sel  = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all(0, "reset dut", 8'h00, 3'd0, 1'b0, 1'b0);
        chk_all(1, "reset d1",  8'h00, 3'd0, 1'b0, 1'b0);
        chk_all(2, "reset al",  8'hFF, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Table: DIRECT decode, IDLE hold, SCAN entry/advance/wrap, back to DIRECT.
        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].en, vecs[i].mode, vecs[i].sel, 0,
                  vecs[i].y, vecs[i].idx, vecs[i].step, vecs[i].act,
                  $sformatf("vec%0d", i));
        end

        // Mode change to DIRECT on the same cycle the count expires.
        do_reset();
        cycle(1'b1, 1'b1, 3'd0, 0, 8'h01, 3'd0, 1'b0, 1'b1, "expiry entry");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 3'd0, 0, 8'h01, 3'd0, 1'b0, 1'b1, $sformatf("expiry hold%0d", i));
        end
        cycle(1'b1, 1'b0, 3'd3, 0, 8'h08, 3'd3, 1'b0, 1'b1, "expiry modechg");
        cycle(1'b1, 1'b1, 3'd5, 0, 8'h20, 3'd5, 1'b0, 1'b1, "rescan reload");

        // DWELL=1: advance every cycle with step held high.
        do_reset();
        cycle(1'b1, 1'b1, 3'd0, 1, 8'h01, 3'd0, 1'b0, 1'b1, "dw1 entry");
        for (int i = 1; i <= 8; i++) begin
            logic [2:0] ei;
            logic [7:0] ey;
            ei = 3'(i % 8);
            ey = 8'd1 << ei;
            cycle(1'b1, 1'b1, 3'd0, 1, ey, ei, 1'b1, 1'b1, $sformatf("dw1 adv%0d", i));
        end

        // Active-low outputs.
        do_reset();
        chk({"al reset", " y"}, y_w[2], 8'hFF);
        cycle(1'b1, 1'b0, 3'd2, 2, 8'hFB, 3'd2, 1'b0, 1'b1, "al direct");
        cycle(1'b0, 1'b0, 3'd2, 2, 8'hFF, 3'd2, 1'b0, 1'b0, "al disable");

        // Asynchronous reset mid-SCAN while step is high at idx=4.
        do_reset();
        cycle(1'b1, 1'b1, 3'd3, 0, 8'h08, 3'd3, 1'b0, 1'b1, "arst entry");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 3'd3, 0, 8'h08, 3'd3, 1'b0, 1'b1, $sformatf("arst hold%0d", i));
        end
        cycle(1'b1, 1'b1, 3'd3, 0, 8'h10, 3'd4, 1'b1, 1'b1, "arst adv");
        rst = 1'b1;
        #1;
        chk_all(0, "arst now", 8'h00, 3'd0, 1'b0, 1'b0);
        en   = 1'b1;
        mode = 1'b1;
        sel  = 3'd6;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b1, 3'd6, 0, 8'h40, 3'd6, 1'b0, 1'b1, "arst restart");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
